l1_pingpong_buffer: RTL and testbench
=====================================

# l1_pingpong_buffer

Double-buffered, multi-lane L1 staging buffer between the L2/DMA fill path and the PE array. It holds two banks of DATA_DEPTH rows × LANE_COUNT lanes. A producer fills and commits one bank while the consumer reads and releases the other. Bank ownership is tracked with per-bank state and valid/ready handshakes, so fill and drain overlap without software arbitration.

## Interface
- DATA_WIDTH, 8: bits per lane element.
- LANE_COUNT, 4: lanes per row.
- DATA_DEPTH, 16: rows per bank; IDX_W = vegeta_clog2(DATA_DEPTH).
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_valid  in  1  write request.
- wr_ready  out  1  current write bank is FREE or FILLING.
- wr_index  in  IDX_W  row to write.
- wr_data  in  DATA_WIDTH × [0:LANE_COUNT-1]  row data.
- wr_lane_mask  in  LANE_COUNT  per-lane write enable; bit i gates lane i.
- wr_commit  in  1  marks the current write bank READY.
- rd_valid  in  1  read request.
- rd_ready  out  1  current read bank is READY.
- rd_index  in  IDX_W  row to read.
- rd_release  in  1  frees the current read bank.
- rd_data  out  DATA_WIDTH × [0:LANE_COUNT-1]  registered read row.
- rd_data_valid  out  1  rd_data carries a new row this cycle.
- banks_ready  out  2  number of banks in READY (0–2).
- err  out  1  sticky protocol error; cleared only by reset.

## Operation
- Per-bank state: FREE, FILLING, READY.
- Pointers: wb is the write bank, rb is the read bank.
- Write fire = wr_valid & wr_ready.
  - Lanes with mask=1 take wr_data at wr_index.
  - Lanes with mask=0 keep their old contents.
  - The first fire moves the bank FREE→FILLING.
- wr_commit while bank[wb] is FREE or FILLING:
  - bank[wb] becomes READY and wb toggles.
  - Committing an empty FREE bank is legal.
- Read fire = rd_valid & rd_ready: row rd_index of bank[rb] is registered to rd_data.
- rd_release while bank[rb] is READY: bank[rb] becomes FREE and rb toggles.
- Error cases (all set err and change no state):
  - wr_commit while bank[wb] is READY is ignored.
  - rd_release while bank[rb] is not READY is ignored.
  - A fire with index ≥ DATA_DEPTH is dropped (write) or returns all zeros (read).
- Same-cycle write fire + wr_commit: the write lands in the bank being committed.
- Same-cycle read fire + rd_release: the read data comes from the released bank.
- Write and read on different banks are fully independent.
- wb == rb with that bank READY: the write side stalls and the read side proceeds.
- Bank storage is not reset; contents are undefined until written.

## Timing
- Reset values:
  - All banks FREE; wb = rb = 0.
  - wr_ready = 1, rd_ready = 0, banks_ready = 0, err = 0.
  - rd_data = all zeros, rd_data_valid = 0.
- Read latency is 1 cycle: a fire at edge N gives rd_data and rd_data_valid = 1 after edge N.
  - rd_data holds its value when there is no fire.
  - rd_data_valid is high for exactly one cycle per fire.
- Write-to-read visibility: a row committed at edge N is readable with rd_ready = 1 in the cycle after edge N.
- Release-to-write: a bank released at edge N is writable (wr_ready = 1) in the cycle after edge N.
- wr_ready, rd_ready and banks_ready are combinational from registered state only; they have no input-to-output path.
- Throughput is one write and one read per cycle at steady state.
- Asserting rst_n mid-operation aborts everything immediately:
  - In-flight rd_data_valid drops.
  - Partially filled banks return to FREE.

## Structure
- Package l1_buffer_pkg holds:
  - the bank_state_t enum {FREE, FILLING, READY};
  - the vegeta_clog2 macro;
  - the lane-row typedef.
- Sub-module l1_bank:
  - one DATA_DEPTH × LANE_COUNT array;
  - masked write port;
  - combinational read mux.
- The top instantiates two l1_bank instances and adds the state/pointer control plus the output register.

## Test plan
- Reset, fill bank 0 rows 0..15 with lane value = row*4+lane, commit, read row 5:
  - rd_data = {20,21,22,23} one cycle after the fire;
  - banks_ready goes 0→1→0 after release.
- Masked write:
  - write row 3 = {1,2,3,4} with mask 4'b1111, then {9,9,9,9} with mask 4'b0101;
  - after commit, a read of row 3 returns lanes {9,2,9,4} (lanes 0 and 2 updated).
- Ping-pong overlap: commit bank 0, fill bank 1 while reading bank 0 every cycle:
  - no stalls;
  - reads return bank 0 data;
  - wr_ready drops only after both banks are committed.
- Boundaries:
  - rd_release with banks_ready = 0 → err = 1, state unchanged;
  - wr_index = 16 with DEPTH = 16 → write dropped, err = 1;
  - same-cycle read fire + release → correct data, then rd_ready = 0.
- Reset mid-fill:
  - rst_n low while bank 1 is FILLING and rd_data_valid = 1;
  - outputs return to reset values immediately;
  - after release, wr_ready = 1 and banks_ready = 0.

Source files
------------

// File: rtl/l1_pingpong_buffer_pkg.sv
// Shared types for the L1 ping-pong staging buffer.
// Width able to hold 0..x, so an index can also express x.
`define VEGETA_CLOG2(x) ($clog2((x) + 1))

package l1_buffer_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int LANE_COUNT = 4;
  localparam int DATA_DEPTH = 16;
  localparam int IDX_W = `VEGETA_CLOG2(DATA_DEPTH);

  typedef enum logic [1:0] {
    FREE,
    FILLING,
    READY
  } bank_state_t;

  typedef logic [0:LANE_COUNT-1][DATA_WIDTH-1:0] lane_row_t;
endpackage

// File: rtl/l1_pingpong_buffer_if.sv
// Fill/drain handshake bundle of the L1 ping-pong buffer.
interface l1_pingpong_buffer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LANE_COUNT = 4,
  parameter int DATA_DEPTH = 16
);
  localparam int IDX_W = `VEGETA_CLOG2(DATA_DEPTH);

  logic                                   wr_valid;
  logic                                   wr_ready;
  logic [IDX_W-1:0]                       wr_index;
  logic [0:LANE_COUNT-1][DATA_WIDTH-1:0]  wr_data;
  logic [LANE_COUNT-1:0]                  wr_lane_mask;
  logic                                   wr_commit;
  logic                                   rd_valid;
  logic                                   rd_ready;
  logic [IDX_W-1:0]                       rd_index;
  logic                                   rd_release;
  logic [0:LANE_COUNT-1][DATA_WIDTH-1:0]  rd_data;
  logic                                   rd_data_valid;
  logic [1:0]                             banks_ready;
  logic                                   err;

  modport master (
    output wr_valid, wr_index, wr_data, wr_lane_mask, wr_commit,
    output rd_valid, rd_index, rd_release,
    input  wr_ready, rd_ready, rd_data, rd_data_valid,
    input  banks_ready, err
  );

  modport slave (
    input  wr_valid, wr_index, wr_data, wr_lane_mask, wr_commit,
    input  rd_valid, rd_index, rd_release,
    output wr_ready, rd_ready, rd_data, rd_data_valid,
    output banks_ready, err
  );
endinterface

// File: rtl/l1_pingpong_buffer_bank.sv
// One L1 bank: lane-masked write port, combinational row read.
module l1_bank #(
  parameter int DATA_WIDTH = 8,
  parameter int LANE_COUNT = 4,
  parameter int DATA_DEPTH = 16,
  parameter int AW = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1
) (
  input  logic                                  clk,
  input  logic                                  we,
  input  logic [AW-1:0]                         wr_row,
  input  logic [0:LANE_COUNT-1][DATA_WIDTH-1:0] wr_data,
  input  logic [LANE_COUNT-1:0]                 wr_mask,
  input  logic [AW-1:0]                         rd_row,
  output logic [0:LANE_COUNT-1][DATA_WIDTH-1:0] rd_data
);
  typedef logic [0:LANE_COUNT-1][DATA_WIDTH-1:0] row_t;

  row_t mem [DATA_DEPTH];

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int l = 0; l < LANE_COUNT; l++) begin
        if (wr_mask[l]) mem[wr_row][l] <= wr_data[l];
      end
    end
  end

  assign rd_data = mem[rd_row];
endmodule

// File: rtl/l1_pingpong_buffer.sv
// Two-bank L1 staging buffer: producer fills one bank while consumer drains the other.
module l1_pingpong_buffer
  import l1_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LANE_COUNT = 4,
  parameter int DATA_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  l1_pingpong_buffer_if.slave  bus
);
  localparam int IDX_W = `VEGETA_CLOG2(DATA_DEPTH);
  localparam int AW = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;

  typedef logic [0:LANE_COUNT-1][DATA_WIDTH-1:0] row_t;

  bank_state_t st_q [2];
  bank_state_t st_d [2];
  logic        wb_q, wb_d;
  logic        rb_q, rb_d;
  logic        err_q, err_d;
  row_t        rd_data_q;
  logic        rd_vld_q;
  row_t        bank_rd [2];
  logic [1:0]  bank_we;
  logic        wr_rdy, rd_rdy;
  logic        wr_fire, rd_fire;
  logic        wr_oob, rd_oob;

  assign wr_rdy  = st_q[wb_q] != READY;
  assign rd_rdy  = st_q[rb_q] == READY;
  assign wr_fire = bus.wr_valid & wr_rdy;
  assign rd_fire = bus.rd_valid & rd_rdy;
  assign wr_oob  = bus.wr_index >= IDX_W'(DATA_DEPTH);
  assign rd_oob  = bus.rd_index >= IDX_W'(DATA_DEPTH);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign bank_we[b] = wr_fire & ~wr_oob & (wb_q == 1'(b));

    l1_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .LANE_COUNT (LANE_COUNT),
      .DATA_DEPTH (DATA_DEPTH),
      .AW         (AW)
    ) u_bank (
      .clk     (clk),
      .we      (bank_we[b]),
      .wr_row  (bus.wr_index[AW-1:0]),
      .wr_data (bus.wr_data),
      .wr_mask (bus.wr_lane_mask),
      .rd_row  (bus.rd_index[AW-1:0]),
      .rd_data (bank_rd[b])
    );
  end

  // Commit and release look only at registered state, so both may act in one cycle.
  always_comb begin
    st_d  = st_q;
    wb_d  = wb_q;
    rb_d  = rb_q;
    err_d = err_q;
    if (wr_fire & ~wr_oob & (st_q[wb_q] == FREE)) begin
      st_d[wb_q] = FILLING;
    end
    if (bus.wr_commit) begin
      if (st_q[wb_q] != READY) begin
        st_d[wb_q] = READY;
        wb_d       = ~wb_q;
      end else begin
        err_d = 1'b1;
      end
    end
    if (bus.rd_release) begin
      if (rd_rdy) begin
        st_d[rb_q] = FREE;
        rb_d       = ~rb_q;
      end else begin
        err_d = 1'b1;
      end
    end
    if ((wr_fire & wr_oob) | (rd_fire & rd_oob)) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q[0]   <= FREE;
      st_q[1]   <= FREE;
      wb_q      <= 1'b0;
      rb_q      <= 1'b0;
      err_q     <= 1'b0;
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
    end else begin
      st_q     <= st_d;
      wb_q     <= wb_d;
      rb_q     <= rb_d;
      err_q    <= err_d;
      rd_vld_q <= rd_fire;
      if (rd_fire) rd_data_q <= rd_oob ? '0 : bank_rd[rb_q];
    end
  end

  assign bus.wr_ready      = wr_rdy;
  assign bus.rd_ready      = rd_rdy;
  assign bus.banks_ready   = {1'b0, st_q[0] == READY} + {1'b0, st_q[1] == READY};
  assign bus.err           = err_q;
  assign bus.rd_data       = rd_data_q;
  assign bus.rd_data_valid = rd_vld_q;
endmodule

// File: tb/tb_l1_pingpong_buffer.sv
// Randomized and directed bench for l1_pingpong_buffer against a bank/pointer model.
module tb_l1_pingpong_buffer;
  import l1_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  l1_pingpong_buffer_if #(
    .DATA_WIDTH (DATA_WIDTH),
    .LANE_COUNT (LANE_COUNT),
    .DATA_DEPTH (DATA_DEPTH)
  ) bus ();

  l1_pingpong_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .LANE_COUNT (LANE_COUNT),
    .DATA_DEPTH (DATA_DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: 0 = free, 1 = filling, 2 = committed
  int mst [2];
  int mwb, mrb;
  logic [DATA_WIDTH-1:0] mmem [2][DATA_DEPTH][LANE_COUNT];
  lane_row_t exp_rd;
  bit exp_v, exp_err;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic lane_row_t model_row(input int b, input int r);
    lane_row_t v;
    for (int l = 0; l < LANE_COUNT; l++) v[l] = mmem[b][r][l];
    return v;
  endfunction

  task automatic model_reset();
    mst[0] = 0;
    mst[1] = 0;
    mwb = 0;
    mrb = 0;
    exp_rd = '0;
    exp_v = 1'b0;
    exp_err = 1'b0;
  endtask

  task automatic drive_idle();
    bus.wr_valid = 0;
    bus.wr_index = '0;
    bus.wr_data = '0;
    bus.wr_lane_mask = '0;
    bus.wr_commit = 0;
    bus.rd_valid = 0;
    bus.rd_index = '0;
    bus.rd_release = 0;
  endtask

  task automatic cycle(input bit wv, input logic [IDX_W-1:0] wi,
                       input lane_row_t wd, input logic [LANE_COUNT-1:0] wm,
                       input bit wc, input bit rv,
                       input logic [IDX_W-1:0] ri, input bit rr);
    bit wrdy, rrdy, wf, rf;
    int nr;
    int ost [2];
    bus.wr_valid = wv;
    bus.wr_index = wi;
    bus.wr_data = wd;
    bus.wr_lane_mask = wm;
    bus.wr_commit = wc;
    bus.rd_valid = rv;
    bus.rd_index = ri;
    bus.rd_release = rr;
    #1;
    wrdy = mst[mwb] != 2;
    rrdy = mst[mrb] == 2;
    nr = int'(mst[0] == 2) + int'(mst[1] == 2);
    chk("wr_ready", bus.wr_ready, wrdy);
    chk("rd_ready", bus.rd_ready, rrdy);
    chk("banks_ready", bus.banks_ready, nr);
    wf = wv && wrdy;
    rf = rv && rrdy;
    ost = mst;
    exp_v = rf;
    if (rf) begin
      if (ri < DATA_DEPTH) exp_rd = model_row(mrb, int'(ri));
      else begin
        exp_rd = '0;
        exp_err = 1'b1;
      end
    end
    if (wf) begin
      if (wi < DATA_DEPTH) begin
        for (int l = 0; l < LANE_COUNT; l++)
          if (wm[l]) mmem[mwb][wi][l] = wd[l];
        if (mst[mwb] == 0) mst[mwb] = 1;
      end else exp_err = 1'b1;
    end
    if (wc) begin
      if (ost[mwb] != 2) begin
        mst[mwb] = 2;
        mwb ^= 1;
      end else exp_err = 1'b1;
    end
    if (rr) begin
      if (ost[mrb] == 2) begin
        mst[mrb] = 0;
        mrb ^= 1;
      end else exp_err = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("rd_data_valid", bus.rd_data_valid, exp_v);
    chk("rd_data", bus.rd_data, exp_rd);
    chk("err", bus.err, exp_err);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, '0, '0, '0, 0, 0, '0, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive_idle();
    #1;
    model_reset();
    chk("rst_rd_data_valid", bus.rd_data_valid, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_wr_ready", bus.wr_ready, 1);
    chk("rst_rd_ready", bus.rd_ready, 0);
    chk("rst_banks_ready", bus.banks_ready, 0);
    chk("rst_err", bus.err, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic lane_row_t seq_row(input int r);
    lane_row_t v;
    for (int l = 0; l < LANE_COUNT; l++) v[l] = DATA_WIDTH'(r * 4 + l);
    return v;
  endfunction

  function automatic logic [IDX_W-1:0] rand_idx();
    if ($urandom_range(0, 15) == 0)
      return IDX_W'(DATA_DEPTH + int'($urandom_range(0, 15)));
    return IDX_W'($urandom_range(0, DATA_DEPTH - 1));
  endfunction

  initial begin
    lane_row_t r1, r2, r3;
    drive_idle();
    do_reset();

    // Fill bank 0 with row*4+lane, commit on the last write
    for (int r = 0; r < DATA_DEPTH; r++)
      cycle(1, IDX_W'(r), seq_row(r), '1, r == DATA_DEPTH - 1, 0, '0, 0);
    chk("banks_ready_after_commit", bus.banks_ready, 1);
    cycle(0, '0, '0, '0, 0, 1, IDX_W'(5), 0);
    r1 = {8'd20, 8'd21, 8'd22, 8'd23};
    chk("row5", bus.rd_data, r1);
    cycle(0, '0, '0, '0, 0, 0, '0, 1);
    chk("banks_ready_after_release", bus.banks_ready, 0);

    // Masked write into bank 1
    for (int r = 0; r < DATA_DEPTH; r++)
      cycle(1, IDX_W'(r), lane_row_t'($urandom), '1, 0, 0, '0, 0);
    r2 = {8'd1, 8'd2, 8'd3, 8'd4};
    cycle(1, IDX_W'(3), r2, 4'b1111, 0, 0, '0, 0);
    r2 = {8'd9, 8'd9, 8'd9, 8'd9};
    cycle(1, IDX_W'(3), r2, 4'b0101, 0, 0, '0, 0);
    cycle(0, '0, '0, '0, 1, 0, '0, 0);
    cycle(0, '0, '0, '0, 0, 1, IDX_W'(3), 0);
    r3 = {8'd9, 8'd2, 8'd9, 8'd4};
    chk("masked_row3", bus.rd_data, r3);
    cycle(0, '0, '0, '0, 0, 0, '0, 1);

    // Ping-pong overlap: drain bank 0 while filling bank 1
    cycle(1, '0, seq_row(0), '1, 1, 0, '0, 0);
    for (int r = 0; r < DATA_DEPTH; r++)
      cycle(1, IDX_W'(r), lane_row_t'($urandom), '1, r == DATA_DEPTH - 1,
            1, IDX_W'(r), 0);
    chk("wr_ready_both_committed", bus.wr_ready, 0);
    chk("banks_ready_both", bus.banks_ready, 2);
    cycle(0, '0, '0, '0, 0, 0, '0, 1);
    cycle(0, '0, '0, '0, 0, 1, IDX_W'(9), 1);
    idle(1);

    // Boundaries
    do_reset();
    cycle(0, '0, '0, '0, 0, 0, '0, 1);
    chk("release_empty_err", bus.err, 1);
    chk("release_empty_banks", bus.banks_ready, 0);
    do_reset();
    cycle(1, IDX_W'(DATA_DEPTH), lane_row_t'($urandom), '1, 0, 0, '0, 0);
    chk("oob_write_err", bus.err, 1);
    cycle(0, '0, '0, '0, 1, 0, '0, 0);
    cycle(0, '0, '0, '0, 0, 1, '0, 0);
    cycle(0, '0, '0, '0, 0, 1, IDX_W'(7), 1);
    chk("read_release_rd_ready", bus.rd_ready, 0);
    idle(1);

    // Reset mid-fill with a read in flight
    do_reset();
    cycle(1, '0, lane_row_t'($urandom), '1, 1, 0, '0, 0);
    cycle(1, IDX_W'(2), lane_row_t'($urandom), 4'b0011, 0, 1, IDX_W'(4), 0);
    chk("inflight_valid", bus.rd_data_valid, 1);
    do_reset();
    idle(2);
    chk("post_reset_wr_ready", bus.wr_ready, 1);
    chk("post_reset_banks", bus.banks_ready, 0);

    // Random traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 9) < 7, rand_idx(), lane_row_t'($urandom),
            LANE_COUNT'($urandom), $urandom_range(0, 6) == 0,
            $urandom_range(0, 9) < 7, rand_idx(),
            $urandom_range(0, 6) == 0);
      if (i == 300) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
